video_bypass_ctrl: RTL
======================

VIDEO_BYPASS_CTRL -- requirements
Module: video_bypass_ctrl

Interface
REQ-001 SHALL have parameter NUM_CORE, default 4, number of daisy-chained video cores controlled.
REQ-002 SHALL have parameter DB_LIMIT, default 1000000, sys_clk cycles a raw input must stay stable before it is accepted.
REQ-003 SHALL have parameter FRAME_TIMEOUT, default 2000000, sys_clk cycles to wait for a frame boundary before forcing an apply.
REQ-004 SHALL have parameter BYPASS_RESET, default all-zero NUM_CORE bits, bypass value after reset.
REQ-005 SHALL have port sys_clk  input  1  system clock; every register is on its rising edge.
REQ-006 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port sw_in  input  NUM_CORE  raw, asynchronous, bouncy bypass requests; bit i is core i.
REQ-008 SHALL have port vsync_in  input  1  VGA vsync from the pixel domain, active-low, asynchronous to sys_clk.
REQ-009 SHALL have port core_bypass  output  NUM_CORE  registered bypass controls to the video cores.
REQ-010 SHALL have port update_pulse  output  1  single-cycle strobe asserted in the cycle core_bypass takes a new value.
REQ-011 SHALL have port pending  output  1  high while an accepted change waits for a frame boundary.

Function
REQ-012 SHALL pass each sw_in bit through a 2-flop synchronizer.
REQ-013 SHALL keep one debounce counter per bit; counter clears whenever the synced bit equals the debounced bit.
REQ-014 SHALL toggle the debounced bit and clear its counter in the cycle that counter reaches DB_LIMIT-1 with a mismatch; otherwise counter increments.
REQ-015 SHALL make a change stable for at least DB_LIMIT+2 cycles visible on the debounced vector; a glitch shorter than DB_LIMIT cycles SHALL NOT change it.
REQ-016 SHALL pass vsync_in through a 2-flop synchronizer plus one delay flop; frame_edge is synced falling edge (1 then 0).
REQ-017 SHALL implement FSM states IDLE, PENDING and APPLY.
REQ-018 IDLE: go to PENDING when debounced != core_bypass.
REQ-019 PENDING: go to IDLE without applying if debounced == core_bypass again (request withdrawn).
REQ-020 PENDING: otherwise go to APPLY on frame_edge or when the timeout counter reaches FRAME_TIMEOUT-1.
REQ-021 PENDING: frame_edge in the same cycle as the withdrawal SHALL be ignored (withdrawal wins).
REQ-022 SHALL load core_bypass with the debounced value of the PENDING->APPLY transition cycle.
REQ-023 APPLY: assert update_pulse for exactly one cycle and return to IDLE unconditionally.
REQ-024 A debounced change arriving during APPLY SHALL be picked up from IDLE on the next cycle.
REQ-025 SHALL hold the timeout counter at 0 outside PENDING and increment it by 1 per cycle in PENDING; it does not wrap.
REQ-026 pending SHALL equal (state == PENDING); update_pulse SHALL equal (state == APPLY).
REQ-027 core_bypass SHALL change only at APPLY entry; no other path writes it.

Reset
REQ-028 On sys_rst high, outputs SHALL take these values immediately, independent of sys_clk:
- core_bypass = BYPASS_RESET, update_pulse = 0, pending = 0
- state = IDLE
- debounce and timeout counters = 0
- sw synchronizers and debounced vector = BYPASS_RESET
- vsync synchronizer and delay flops = 1, so no false edge
REQ-029 Reset asserted mid-PENDING or mid-APPLY SHALL discard the request; after release the block re-evaluates from IDLE.

Verification (DB_LIMIT=4, FRAME_TIMEOUT=100, NUM_CORE=4, BYPASS_RESET=0)
REQ-030 Reset then idle: sw_in=0000, vsync toggling -> core_bypass=0000, update_pulse and pending never high.
REQ-031 Normal apply: sw_in=0010 held stable, then vsync falls -> pending rises ~6 cycles after the change and stays high until the frame edge; 3-4 cycles after vsync falls, update_pulse for one cycle and core_bypass=0010.
REQ-032 Glitch rejection: sw_in bit0 high for 3 cycles, then low -> debounced unchanged, pending stays 0.
REQ-033 Withdrawal: sw_in=0100 accepted (pending=1), then sw_in=0000 held before any vsync edge -> pending drops, no update_pulse, core_bypass=0000.
REQ-034 Timeout: sw_in=1000 accepted, vsync held high -> update_pulse exactly 100 cycles after pending rises (101st PENDING cycle), core_bypass=1000.
REQ-035 Reset mid-operation: sys_rst pulsed while pending=1 with sw_in=0001 held -> outputs 0000/0/0 at once; after release, pending re-asserts after the debounce delay.

Source files
------------

// File: rtl/video_bypass_ctrl.sv
// Bypass control for a chain of video cores: debounces raw switch requests and
// applies them to the cores only on a frame boundary, or after a frame timeout.
module video_bypass_ctrl #(
    parameter int                  NUM_CORE      = 4,
    parameter int                  DB_LIMIT      = 1000000,
    parameter int                  FRAME_TIMEOUT = 2000000,
    parameter logic [NUM_CORE-1:0] BYPASS_RESET  = '0
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_CORE-1:0] sw_in,
    input  logic                vsync_in,
    output logic [NUM_CORE-1:0] core_bypass,
    output logic                update_pulse,
    output logic                pending
);

    localparam int DBW = (DB_LIMIT > 1) ? $clog2(DB_LIMIT) : 1;
    localparam int TOW = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT + 1) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_LIMIT - 1);
    localparam logic [TOW-1:0] TO_LAST = TOW'(FRAME_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_APPLY   = 2'd2;

    logic [NUM_CORE-1:0] sw_sync1_q;
    logic [NUM_CORE-1:0] sw_sync2_q;
    logic [NUM_CORE-1:0] db_q;
    logic [NUM_CORE-1:0] db_d;
    logic [DBW-1:0]      db_cnt_q [NUM_CORE];
    logic [DBW-1:0]      db_cnt_d [NUM_CORE];

    logic                vs_sync1_q;
    logic                vs_sync2_q;
    logic                vs_dly_q;
    logic                frame_edge_s;

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [TOW-1:0]      tmo_q;
    logic [TOW-1:0]      tmo_d;
    logic [NUM_CORE-1:0] core_bypass_q;
    logic [NUM_CORE-1:0] core_bypass_d;
    logic                update_pulse_q;
    logic                pending_q;

    // Synchronizers; vsync flops reset high so release cannot fake a falling edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sw_sync1_q <= BYPASS_RESET;
            sw_sync2_q <= BYPASS_RESET;
            vs_sync1_q <= 1'b1;
            vs_sync2_q <= 1'b1;
            vs_dly_q   <= 1'b1;
        end else begin
            sw_sync1_q <= sw_in;
            sw_sync2_q <= sw_sync1_q;
            vs_sync1_q <= vsync_in;
            vs_sync2_q <= vs_sync1_q;
            vs_dly_q   <= vs_sync2_q;
        end
    end

    assign frame_edge_s = vs_dly_q & ~vs_sync2_q;

    // Per-bit debounce: a mismatch must persist DB_LIMIT evaluations to flip the bit.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < NUM_CORE; i++) begin
            if (sw_sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i] = '0;
                db_d[i]     = ~db_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            db_q <= BYPASS_RESET;
            for (int i = 0; i < NUM_CORE; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // Apply FSM; a withdrawn request beats a coincident frame edge or timeout.
    always_comb begin
        state_d       = state_q;
        core_bypass_d = core_bypass_q;
        tmo_d         = '0;
        case (state_q)
            ST_IDLE: begin
                if (db_q != core_bypass_q) begin
                    state_d = ST_PENDING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (db_q == core_bypass_q) begin
                    state_d = ST_IDLE;
                end else if (frame_edge_s || (tmo_q == TO_LAST)) begin
                    state_d       = ST_APPLY;
                    core_bypass_d = db_q;
                end else begin
                    state_d = ST_PENDING;
                    tmo_d   = tmo_q + 1'b1;
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, timeout counter and registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q        <= ST_IDLE;
            tmo_q          <= '0;
            core_bypass_q  <= BYPASS_RESET;
            update_pulse_q <= 1'b0;
            pending_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmo_q          <= tmo_d;
            core_bypass_q  <= core_bypass_d;
            update_pulse_q <= (state_d == ST_APPLY);
            pending_q      <= (state_d == ST_PENDING);
        end
    end

    assign core_bypass  = core_bypass_q;
    assign update_pulse = update_pulse_q;
    assign pending      = pending_q;

endmodule
